// File: rtl/datamover_cmd_issuer_if.sv
// Request, DataMover command and DataMover status channels of the S2MM command issuer.
// Ports: s_req_* (write requests in), M_AXIS_CMD_* (command stream out),
//        S_AXIS_STS_* (8-bit status stream in). master = issuer side, slave = surroundings.
interface datamover_cmd_issuer_if #(
  parameter int ADDR_WIDTH = 64
);
  // Write request from the frame writer
  logic [ADDR_WIDTH-1:0]  s_req_addr;
  logic [22:0]            s_req_len;
  logic                   s_req_eof;
  logic                   s_req_valid;
  logic                   s_req_ready;

  // Command stream towards the DataMover
  logic [ADDR_WIDTH+39:0] M_AXIS_CMD_tdata;
  logic                   M_AXIS_CMD_tvalid;
  logic                   M_AXIS_CMD_tready;

  // Status stream back from the DataMover
  logic [7:0]             S_AXIS_STS_tdata;
  logic                   S_AXIS_STS_tkeep;
  logic                   S_AXIS_STS_tlast;
  logic                   S_AXIS_STS_tvalid;
  logic                   S_AXIS_STS_tready;

  modport master (
    input  s_req_addr, s_req_len, s_req_eof, s_req_valid,
    output s_req_ready,
    output M_AXIS_CMD_tdata, M_AXIS_CMD_tvalid,
    input  M_AXIS_CMD_tready,
    input  S_AXIS_STS_tdata, S_AXIS_STS_tkeep, S_AXIS_STS_tlast, S_AXIS_STS_tvalid,
    output S_AXIS_STS_tready
  );

  modport slave (
    output s_req_addr, s_req_len, s_req_eof, s_req_valid,
    input  s_req_ready,
    input  M_AXIS_CMD_tdata, M_AXIS_CMD_tvalid,
    output M_AXIS_CMD_tready,
    output S_AXIS_STS_tdata, S_AXIS_STS_tkeep, S_AXIS_STS_tlast, S_AXIS_STS_tvalid,
    input  S_AXIS_STS_tready
  );
endinterface

// File: rtl/datamover_cmd_issuer.sv
// Purpose: turns write requests into tagged AXI DataMover S2MM commands, bounds outstanding
//          commands and latches the first failing status (tag + cause).
// Latency: request handshake -> command valid next cycle; status -> flags next cycle.
// Backpressure: one-entry command register; s_req_ready drops while it is full, while the
//          outstanding limit is reached, or after an error. Status is always accepted out of reset.
// Ports: clk, resetn (sync, active-low); bus (datamover_cmd_issuer_if.master: s_req_*,
//        M_AXIS_CMD_*, S_AXIS_STS_*); outstanding, idle, err_encountered, err_tag, err_code,
//        cmd_count, sts_count.
// Option: define DATAMOVER_TAG_CHECK_EN to require statuses to return in issue (tag) order.
module datamover_cmd_issuer #(
  parameter int ADDR_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  datamover_cmd_issuer_if.master bus,
  output logic [3:0]             outstanding,
  output logic                   idle,
  output logic                   err_encountered,
  output logic [3:0]             err_tag,
  output logic [3:0]             err_code,
  output logic [31:0]            cmd_count,
  output logic [31:0]            sts_count
);

  localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } cmd_state_t;

  cmd_state_t             state;
  logic [ADDR_WIDTH+39:0] cmd_tdata;
  logic [3:0]             issue_tag;

  logic       req_hs;
  logic       cmd_hs;
  logic       sts_hs;
  logic       sts_dec;
  logic [3:0] sts_tag;
  logic       st_interr;
  logic       st_decerr;
  logic       st_slverr;
  logic       st_okay;
  logic       st_protocol;
  logic       st_err;

`ifdef DATAMOVER_TAG_CHECK_EN
  logic [3:0] exp_tag;
`endif

  // tkeep/tlast carry nothing for an 8-bit single-beat status
  wire unused_sts = &{1'b0, bus.S_AXIS_STS_tkeep, bus.S_AXIS_STS_tlast};

  assign bus.s_req_ready       = resetn & (state == EMPTY) & ~err_encountered &
                                 (outstanding < MAX_OUT);
  assign bus.M_AXIS_CMD_tvalid = (state == FULL);
  assign bus.M_AXIS_CMD_tdata  = cmd_tdata;
  assign bus.S_AXIS_STS_tready = resetn;

  assign req_hs = bus.s_req_valid & bus.s_req_ready;
  assign cmd_hs = bus.M_AXIS_CMD_tvalid & bus.M_AXIS_CMD_tready;
  assign sts_hs = bus.S_AXIS_STS_tvalid & resetn;

  assign sts_tag   = bus.S_AXIS_STS_tdata[3:0];
  assign st_interr = bus.S_AXIS_STS_tdata[4];
  assign st_decerr = bus.S_AXIS_STS_tdata[5];
  assign st_slverr = bus.S_AXIS_STS_tdata[6];
  assign st_okay   = bus.S_AXIS_STS_tdata[7];

  // A status with nothing outstanding is not matched to any command; the counter
  // must not wrap below zero, so it simply stays at 0.
  assign sts_dec = sts_hs & (outstanding != 4'd0);

`ifdef DATAMOVER_TAG_CHECK_EN
  assign st_protocol = (outstanding == 4'd0) | (sts_tag != exp_tag);
`else
  assign st_protocol = (outstanding == 4'd0);
`endif

  assign st_err = ~st_okay | st_interr | st_decerr | st_slverr | st_protocol;

  assign idle = (state == EMPTY) & (outstanding == 4'd0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state           <= EMPTY;
      cmd_tdata       <= '0;
      issue_tag       <= 4'd0;
      outstanding     <= 4'd0;
      err_encountered <= 1'b0;
      err_tag         <= 4'd0;
      err_code        <= 4'd0;
      cmd_count       <= 32'd0;
      sts_count       <= 32'd0;
`ifdef DATAMOVER_TAG_CHECK_EN
      exp_tag         <= 4'd0;
`endif
    end else begin
      case (state)
        EMPTY: begin
          // Zero-length requests are swallowed: the register stays empty.
          if (req_hs && (bus.s_req_len != 23'd0)) begin
            // Only one command is ever held, so issue_tag here is the tag it will leave with.
            cmd_tdata <= {4'h0, issue_tag, bus.s_req_addr, 1'b0, bus.s_req_eof,
                          6'h00, 1'b1, bus.s_req_len};
            state     <= FULL;
          end
        end
        FULL: begin
          if (cmd_hs) state <= EMPTY;
        end
        default: state <= EMPTY;
      endcase

      if (cmd_hs) begin
        issue_tag <= issue_tag + 4'd1;
        cmd_count <= cmd_count + 32'd1;
      end

      outstanding <= outstanding + {3'b000, cmd_hs} - {3'b000, sts_dec};

      if (sts_hs) begin
        sts_count <= sts_count + 32'd1;
`ifdef DATAMOVER_TAG_CHECK_EN
        exp_tag   <= exp_tag + 4'd1;
`endif
        if (st_err && !err_encountered) begin
          err_encountered <= 1'b1;
          err_tag         <= sts_tag;
          err_code        <= {st_protocol, st_slverr, st_decerr, st_interr};
        end
      end
    end
  end

endmodule

// File: doc/datamover_cmd_issuer.md
# datamover_cmd_issuer

- Initiator side of the AXI DataMover S2MM command/status pair.
- Converts write requests (address, byte count, end-of-frame) into DataMover command words, stamped with a rolling 4-bit tag, and limits the number of outstanding commands.
- Consumes the 8-bit status stream and latches the first error (with its tag and cause).
- Sits between the frame-writer logic and the DataMover IP in the host-memory write path.

## Interface

Parameters:
- ADDR_WIDTH, 64, address width; command SADDR field width.
- MAX_OUTSTANDING, 8, maximum commands issued without a returned status; 1..15.

Ports (reset resetn, synchronous, active-low; clock clk):
- clk  in  1  clock, all logic on rising edge.
- resetn  in  1  synchronous active-low reset.
- s_req_addr  in  ADDR_WIDTH  destination byte address.
- s_req_len  in  23  bytes to transfer (BTT).
- s_req_eof  in  1  request ends a frame; sets command EOF bit.
- s_req_valid  in  1  request valid.
- s_req_ready  out  1  request accepted when valid&ready.
- M_AXIS_CMD_tdata  out  ADDR_WIDTH+40  command word.
- M_AXIS_CMD_tvalid  out  1  command valid.
- M_AXIS_CMD_tready  in  1  DataMover accepts command.
- S_AXIS_STS_tdata  in  8  status: [3:0] TAG, [4] INTERR, [5] DECERR, [6] SLVERR, [7] OKAY.
- S_AXIS_STS_tkeep  in  1  ignored.
- S_AXIS_STS_tlast  in  1  ignored.
- S_AXIS_STS_tvalid  in  1  status valid.
- S_AXIS_STS_tready  out  1  equals resetn.
- outstanding  out  4  issued commands awaiting status.
- idle  out  1  no command held, outstanding==0.
- err_encountered  out  1  sticky error flag.
- err_tag  out  4  tag of the first erroneous status.
- err_code  out  4  {PROTOCOL, SLVERR, DECERR, INTERR} of the first error.
- cmd_count  out  32  commands handed to DataMover, wraps.
- sts_count  out  32  statuses consumed, wraps.

## Operation

Command word layout:
- [22:0] BTT
- [23] Type=1 (INCR)
- [29:24] DSA=0
- [30] EOF
- [31] DRR=0
- [ADDR_WIDTH+31:32] SADDR
- [ADDR_WIDTH+35:ADDR_WIDTH+32] TAG
- [ADDR_WIDTH+39:ADDR_WIDTH+36] 0

Command register:
- Holds one command.
- States: EMPTY, FULL. EMPTY->FULL on a request handshake with s_req_len!=0. FULL->EMPTY on the M_AXIS_CMD handshake.
- M_AXIS_CMD_tvalid equals FULL.
- tdata is stable while tvalid is high and tready is low.

Request acceptance:
- s_req_ready = resetn & EMPTY & !err_encountered & (outstanding < MAX_OUTSTANDING).
- A request with s_req_len==0 is accepted and discarded. No command is issued, the tag is not advanced and counters do not change.

Tags:
- issue_tag starts at 0 and increments modulo 16 on each command handshake, 15->0.

Outstanding counter:
- +1 on a command handshake; -1 on a status handshake.
- When both handshakes occur in the same cycle, the counter is unchanged.

Status handling, on every cycle with S_AXIS_STS_tvalid & resetn:
- sts_count increments.
- An error is detected when OKAY==0, or INTERR|DECERR|SLVERR==1, or outstanding==0 (unexpected status; PROTOCOL bit set, outstanding stays at 0).
- If err_encountered is 0: set it, and latch err_tag=TAG and err_code.
- Later errors do not change the latched values.

After an error:
- No new requests are accepted.
- A command already held in the register is still presented until handshaked.
- Statuses are still consumed and counted.
- Only resetn clears the error state.

## Timing

- Request handshake at edge N -> M_AXIS_CMD_tvalid high after edge N (cycle N+1); no combinational path from s_req to M_AXIS_CMD.
- Back-to-back requests: at most one command per two cycles, because s_req_ready requires EMPTY.
- Command handshake at edge N -> outstanding, cmd_count and issue_tag updated after edge N.
- Status at edge N -> err_*, outstanding and sts_count updated after edge N.
- S_AXIS_STS_tready is combinationally resetn.
- idle is registered-equivalent: derived only from state registers.
- Reset values:
  - M_AXIS_CMD_tvalid=0, s_req_ready=0 (during reset)
  - outstanding=0, idle=1
  - err_encountered=0, err_tag=0, err_code=0
  - cmd_count=0, sts_count=0, issue_tag=0
- Reset mid-operation drops the held command and all outstanding accounting immediately.

## Configuration

DATAMOVER_TAG_CHECK_EN:
- Defined: an expected-tag counter (reset 0, +1 mod 16 per consumed status) is compared against status TAG. A mismatch is an error with PROTOCOL set. Statuses must return in issue order.
- Undefined: the TAG field is ignored apart from err_tag capture, and PROTOCOL is set only by an unexpected status.

## Test plan

- Single request addr=0x1000, len=4096, eof=1 -> one command with BTT=4096, Type=1, EOF=1, SADDR=0x1000, TAG=0; status 0x80 -> outstanding back to 0, idle=1, err_encountered=0.
- M_AXIS_CMD_tready held low for 5 cycles after tvalid -> tdata stable, s_req_ready=0, then handshake; 20 commands issued -> tags run 0..15,0..3; cmd_count=20.
- MAX_OUTSTANDING=8, no statuses -> 8 commands issued, s_req_ready stays 0; one status 0x80 -> exactly one more command is accepted.
- Status 0xC3 (OKAY+SLVERR, TAG 3) -> err_encountered=1, err_tag=3, err_code=0b0100; a following status 0x90 leaves err_tag and err_code unchanged; s_req_ready=0 until reset.
- Status with outstanding=0 -> err_code=0b1000, outstanding stays 0; with DATAMOVER_TAG_CHECK_EN, status TAG 5 when tag 0 is expected -> PROTOCOL error, err_tag=5.
- Simultaneous command and status handshakes with outstanding=3 -> outstanding stays 3; a request with len=0 -> accepted, no command issued, tag unchanged.
